// File: rtl/rvvi_tx_arb.sv
// rvvi_tx_arb: frame-atomic arbiter sharing the MAC tx stream between the RVVI source (0) and the control source (1).
// Source 1 has priority, limited by a burst cap. Define RVVI_TX_ARB_STATS_EN to enable the per-source frame counters.
module rvvi_tx_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int MAX_BURST  = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  m_axi_aclk,
    input  logic                  m_axi_aresetn,
    input  logic [DATA_WIDTH-1:0] S0Tdata,
    input  logic [KEEP_WIDTH-1:0] S0Tkeep,
    input  logic                  S0Tvalid,
    input  logic                  S0Tlast,
    output logic                  S0Tready,
    input  logic [DATA_WIDTH-1:0] S1Tdata,
    input  logic [KEEP_WIDTH-1:0] S1Tkeep,
    input  logic                  S1Tvalid,
    input  logic                  S1Tlast,
    output logic                  S1Tready,
    output logic [DATA_WIDTH-1:0] MTdata,
    output logic [KEEP_WIDTH-1:0] MTkeep,
    output logic                  MTvalid,
    output logic                  MTlast,
    input  logic                  MTready,
    output logic [1:0]            Owner,
    output logic                  Busy,
    output logic [31:0]           S0Frames,
    output logic [31:0]           S1Frames
);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, GAP} state_e;

    state_e     state_q, state_d;
    logic [3:0] burst_q, burst_d, gap_q, gap_d;
    logic       g0, g1, frame_end;

    always_comb begin
        g0        = state_q == GRANT0;
        g1        = state_q == GRANT1;
        MTvalid   = g0 ? S0Tvalid : g1 ? S1Tvalid : 1'b0;
        MTlast    = g0 ? S0Tlast : g1 ? S1Tlast : 1'b0;
        MTdata    = g0 ? S0Tdata : g1 ? S1Tdata : '0;
        MTkeep    = g0 ? S0Tkeep : g1 ? S1Tkeep : '0;
        S0Tready  = g0 & MTready;
        S1Tready  = g1 & MTready;
        frame_end = MTvalid & MTready & MTlast;
        Owner     = {g1, g0};
        Busy      = state_q != IDLE;
        state_d   = state_q;
        burst_d   = burst_q;
        gap_d     = gap_q;
        case (state_q)
            IDLE: begin
                // The burst cap only matters while source 0 is actually waiting.
                if (S1Tvalid && (!S0Tvalid || burst_q < 4'(MAX_BURST))) begin
                    state_d = GRANT1;
                    burst_d = S0Tvalid ? burst_q + 4'd1 : 4'd0;
                end else if (S0Tvalid) begin
                    state_d = GRANT0;
                    burst_d = 4'd0;
                end
            end
            GRANT0, GRANT1: begin
                if (frame_end) begin
                    state_d = GAP_CYCLES > 0 ? GAP : IDLE;
                    gap_d   = GAP_CYCLES > 0 ? 4'(GAP_CYCLES - 1) : 4'd0;
                end
            end
            default: begin
                if (gap_q == 4'd0) state_d = IDLE;
                else gap_d = gap_q - 4'd1;
            end
        endcase
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q <= IDLE;
            burst_q <= 4'd0;
            gap_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            gap_q   <= gap_d;
        end
    end

`ifdef RVVI_TX_ARB_STATS_EN
    logic [31:0] s0_frames_q, s0_frames_d, s1_frames_q, s1_frames_d;

    always_comb begin
        s0_frames_d = s0_frames_q + {31'd0, frame_end & g0};
        s1_frames_d = s1_frames_q + {31'd0, frame_end & g1};
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            s0_frames_q <= 32'd0;
            s1_frames_q <= 32'd0;
        end else begin
            s0_frames_q <= s0_frames_d;
            s1_frames_q <= s1_frames_d;
        end
    end

    assign S0Frames = s0_frames_q;
    assign S1Frames = s1_frames_q;
`else
    assign S0Frames = 32'd0;
    assign S1Frames = 32'd0;
`endif
endmodule

// File: tb/tb_rvvi_tx_arb.sv
// tb_rvvi_tx_arb: directed bench for rvvi_tx_arb with a cycle-timed arbitration model checked every cycle,
// plus a second zero-gap instance for the back-to-back turnaround case.
module tb_rvvi_tx_arb;
    localparam int MAXB = 4;
    localparam int GAP  = 2;
`ifdef RVVI_TX_ARB_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic [31:0] S0Tdata, S1Tdata, MTdata, S0Frames, S1Frames;
    logic [3:0]  S0Tkeep, S1Tkeep, MTkeep;
    logic        S0Tvalid, S0Tlast, S0Tready, S1Tvalid, S1Tlast, S1Tready;
    logic        MTvalid, MTlast, MTready, Busy;
    logic [1:0]  Owner;

    logic [31:0] z_data, z_mdata, z_f0, z_f1;
    logic [3:0]  z_keep, z_mkeep;
    logic        z_valid, z_last, z_ready, z_s1_ready, z_mvalid, z_mlast, z_busy;
    logic [1:0]  z_owner;
    logic [31:0] zero32 = 32'd0;
    logic [3:0]  zero4  = 4'd0;
    logic        zero1  = 1'b0;
    logic        one1   = 1'b1;

    rvvi_tx_arb #(.MAX_BURST(MAXB), .GAP_CYCLES(GAP)) dut (
        .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
        .S0Tdata(S0Tdata), .S0Tkeep(S0Tkeep), .S0Tvalid(S0Tvalid), .S0Tlast(S0Tlast), .S0Tready(S0Tready),
        .S1Tdata(S1Tdata), .S1Tkeep(S1Tkeep), .S1Tvalid(S1Tvalid), .S1Tlast(S1Tlast), .S1Tready(S1Tready),
        .MTdata(MTdata), .MTkeep(MTkeep), .MTvalid(MTvalid), .MTlast(MTlast), .MTready(MTready),
        .Owner(Owner), .Busy(Busy), .S0Frames(S0Frames), .S1Frames(S1Frames)
    );

    rvvi_tx_arb #(.MAX_BURST(MAXB), .GAP_CYCLES(0)) u_z (
        .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
        .S0Tdata(z_data), .S0Tkeep(z_keep), .S0Tvalid(z_valid), .S0Tlast(z_last), .S0Tready(z_ready),
        .S1Tdata(zero32), .S1Tkeep(zero4), .S1Tvalid(zero1), .S1Tlast(zero1), .S1Tready(z_s1_ready),
        .MTdata(z_mdata), .MTkeep(z_mkeep), .MTvalid(z_mvalid), .MTlast(z_mlast), .MTready(one1),
        .Owner(z_owner), .Busy(z_busy), .S0Frames(z_f0), .S1Frames(z_f1)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Source queues hold {last, keep, data}; the head beat is presented until handshaken.
    logic [36:0] q0[$], q1[$], qz[$];
    int          stall0 = 0;
    logic        t0 = 1'b0, t1 = 1'b0, tz = 1'b0;
    logic [34:0] lg[$];
    int          zcyc[$];
    logic [36:0] zbeat[$];
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        t0 = S0Tvalid && S0Tready;
        t1 = S1Tvalid && S1Tready;
        tz = z_valid && z_ready;
        if (MTvalid && MTready) lg.push_back({Owner, MTlast, MTdata});
        if (z_mvalid) begin
            zcyc.push_back(cyc);
            zbeat.push_back({z_mlast, z_mkeep, z_mdata});
        end
    end

    // Model: who owns the bus, and how many forced-idle cycles remain after a frame.
    int          m_owner = 0, m_gap = 0, m_run = 0;
    logic [31:0] m_f0 = 32'd0, m_f1 = 32'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= 0;
            m_gap   <= 0;
            m_run   <= 0;
            m_f0    <= 32'd0;
            m_f1    <= 32'd0;
        end else if (m_owner != 0) begin
            if (MTready && (m_owner == 1 ? (S0Tvalid && S0Tlast) : (S1Tvalid && S1Tlast))) begin
                m_owner <= 0;
                m_gap   <= GAP;
`ifdef RVVI_TX_ARB_STATS_EN
                if (m_owner == 1) m_f0 <= m_f0 + 1;
                else m_f1 <= m_f1 + 1;
`endif
            end
        end else if (m_gap > 0) begin
            m_gap <= m_gap - 1;
        end else if (S1Tvalid && (!S0Tvalid || m_run < MAXB)) begin
            m_owner <= 2;
            m_run   <= S0Tvalid ? m_run + 1 : 0;
        end else if (S0Tvalid) begin
            m_owner <= 1;
            m_run   <= 0;
        end
    end

    logic        e_valid;
    logic [36:0] e_beat;

    always @(negedge clk) begin
        if (rst_n) begin
            e_valid = m_owner == 1 ? S0Tvalid : m_owner == 2 ? S1Tvalid : 1'b0;
            e_beat  = m_owner == 1 ? {S0Tlast, S0Tkeep, S0Tdata} :
                      m_owner == 2 ? {S1Tlast, S1Tkeep, S1Tdata} : 37'd0;
            chk("owner", 64'(Owner), 64'(m_owner));
            chk("busy", 64'(Busy), 64'(m_owner != 0 || m_gap > 0));
            chk("mtvalid", 64'(MTvalid), 64'(e_valid));
            chk("mtbeat", 64'({MTlast, MTkeep, MTdata}), 64'(e_beat));
            chk("s0tready", 64'(S0Tready), 64'(m_owner == 1 && MTready));
            chk("s1tready", 64'(S1Tready), 64'(m_owner == 2 && MTready));
            chk("s0frames", 64'(S0Frames), 64'(m_f0));
            chk("s1frames", 64'(S1Frames), 64'(m_f1));
        end
    end

    task automatic present();
        S0Tvalid = q0.size() != 0 && stall0 == 0;
        {S0Tlast, S0Tkeep, S0Tdata} = q0.size() != 0 ? q0[0] : 37'd0;
        S1Tvalid = q1.size() != 0;
        {S1Tlast, S1Tkeep, S1Tdata} = q1.size() != 0 ? q1[0] : 37'd0;
        z_valid = qz.size() != 0;
        {z_last, z_keep, z_data} = qz.size() != 0 ? qz[0] : 37'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (t0 && q0.size() != 0) void'(q0.pop_front());
        if (t1 && q1.size() != 0) void'(q1.pop_front());
        if (tz && qz.size() != 0) void'(qz.pop_front());
        if (stall0 > 0) stall0--;
        present();
    endtask

    function automatic logic [36:0] beat(input int n, input int i, input int tag);
        return {i == n - 1, (i == n - 1) ? 4'h7 : 4'hF, 32'(tag * 256 + i)};
    endfunction

    task automatic push(input int src, input int n, input int tag);
        for (int i = 0; i < n; i++) begin
            if (src == 0) q0.push_back(beat(n, i, tag));
            else if (src == 1) q1.push_back(beat(n, i, tag));
            else qz.push_back(beat(n, i, tag));
        end
        present();
    endtask

    task automatic wait_lg(input int n, input string nm);
        for (int i = 0; i < 40 && lg.size() < n; i++) step();
        chk(nm, 64'(lg.size() >= n), 64'd1);
    endtask

    int base;
    int zb;

    initial begin
        rst_n   = 1'b1;
        MTready = 1'b1;
        present();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_owner", 64'(Owner), 64'd0);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_mtvalid", 64'(MTvalid), 64'd0);
        chk("rst_s0tready", 64'(S0Tready), 64'd0);
        chk("rst_s1tready", 64'(S1Tready), 64'd0);
        chk("rst_s0frames", 64'(S0Frames), 64'd0);
        step();
        step();
        rst_n = 1'b1;

        // Single 5-beat S0 frame: grant next cycle, idle again at t+GAP+1.
        step();
        base = lg.size();
        push(0, 5, 'h01);
        #3 chk("t1_owner_pre", 64'(Owner), 64'd0);
        step();
        #3;
        chk("t1_owner", 64'(Owner), 64'd1);
        chk("t1_s0tready", 64'(S0Tready), 64'd1);
        repeat (6) step();
        #3 chk("t1_busy_gap", 64'(Busy), 64'd1);
        step();
        #3 chk("t1_busy_idle", 64'(Busy), 64'd0);
        chk("t1_nbeats", 64'(lg.size() - base), 64'd5);
        for (int i = 0; i < 5; i++)
            chk("t1_beat", 64'(lg[base + i]), 64'({2'b01, i == 4, 32'h100 + 32'(i)}));
        chk("t1_s0frames", 64'(S0Frames), 64'(STATS));

        // Both sources valid with 1-beat frames: S1 x4 then S0, repeating.
        base = lg.size();
        for (int i = 0; i < 8; i++) push(1, 1, 'h20 + i);
        for (int i = 0; i < 2; i++) push(0, 1, 'h28 + i);
        repeat (50) step();
        chk("t2_nframes", 64'(lg.size() - base), 64'd10);
        for (int i = 0; i < 10; i++)
            chk("t2_order", 64'(lg[base + i][34:33]), (i % 5 == 4) ? 64'd1 : 64'd2);
        for (int i = 0; i < 10; i++)
            chk("t2_data", 64'(lg[base + i][31:0]),
                64'((i % 5 == 4) ? 32'h2800 + 32'((i / 5) * 256) : 32'h2000 + 32'((i - i / 5) * 256)));

        // Backpressure: MTready alternates during a 4-beat S1 frame.
        base = lg.size();
        push(1, 4, 'h30);
        for (int i = 0; i < 12; i++) begin
            step();
            MTready = (i % 2 == 0);
        end
        MTready = 1'b1;
        repeat (6) step();
        chk("t3_nbeats", 64'(lg.size() - base), 64'd4);
        for (int i = 0; i < 4; i++)
            chk("t3_beat", 64'(lg[base + i]), 64'({2'b10, i == 3, 32'h3000 + 32'(i)}));

        // Source stall: S0 drops valid for 10 cycles mid-frame; S1 must wait.
        base = lg.size();
        push(0, 6, 'h40);
        wait_lg(base + 3, "t4_start");
        stall0 = 10;
        push(1, 1, 'h41);
        for (int i = 0; i < 10; i++) begin
            step();
            #3 chk("t4_owner_held", 64'(Owner), 64'd1);
        end
        repeat (20) step();
        chk("t4_nbeats", 64'(lg.size() - base), 64'd7);
        for (int i = 0; i < 6; i++)
            chk("t4_s0beat", 64'(lg[base + i]), 64'({2'b01, i == 5, 32'h4000 + 32'(i)}));
        chk("t4_s1beat", 64'(lg[base + 6]), 64'({2'b10, 1'b1, 32'h4100}));

        // Reset at beat 3 of 6: outputs drop immediately, then a fresh S1 grant.
        base = lg.size();
        push(0, 6, 'h50);
        wait_lg(base + 2, "t5_start");
        #2 rst_n = 1'b0;
        #1;
        chk("t5_mtvalid", 64'(MTvalid), 64'd0);
        chk("t5_owner", 64'(Owner), 64'd0);
        chk("t5_busy", 64'(Busy), 64'd0);
        chk("t5_s0tready", 64'(S0Tready), 64'd0);
        q0.delete();
        present();
        step();
        step();
        rst_n = 1'b1;
        step();
        push(1, 1, 'h51);
        step();
        #3;
        chk("t5_regrant_owner", 64'(Owner), 64'd2);
        chk("t5_regrant_valid", 64'(MTvalid), 64'd1);
        chk("t5_regrant_ready", 64'(S1Tready), 64'd1);
        repeat (6) step();

        // Zero gap: back-to-back 2-beat S0 frames, next first beat 2 cycles after tlast.
        zb = zcyc.size();
        push(2, 2, 'h60);
        push(2, 2, 'h61);
        repeat (12) step();
        chk("t6_nbeats", 64'(zcyc.size() - zb), 64'd4);
        chk("t6_intra", 64'(zcyc[zb + 1] - zcyc[zb]), 64'd1);
        chk("t6_turnaround", 64'(zcyc[zb + 2] - zcyc[zb + 1]), 64'd2);
        for (int i = 0; i < 4; i++)
            chk("t6_beat", 64'(zbeat[zb + i]), 64'(beat(2, i % 2, 'h60 + i / 2)));
        chk("t6_owner", 64'(z_owner), 64'd0);
        chk("t6_busy", 64'(z_busy), 64'd0);
        chk("t6_s1tready", 64'(z_s1_ready), 64'd0);
        chk("t6_s0frames", 64'(z_f0), 64'(2 * STATS));
        chk("t6_s1frames", 64'(z_f1), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
